// File: rtl/io_input_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_input_bank_pkg
// Description : Shared constants, types and helpers for the input bank:
//               parameter limits, register-index offsets, field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package io_input_bank_pkg;

  // Legal parameter ranges
  localparam int MIN_PORTS      = 1;
  localparam int MAX_PORTS      = 8;
  localparam int MIN_DATA_W     = 1;
  localparam int MAX_DATA_W     = 32;
  localparam int MAX_DEB_CYCLES = 255;

  // Bus and counter widths
  localparam int REG_W = 32;
  localparam int IDX_W = 6;
  localparam int CNT_W = 8;

  typedef logic [IDX_W-1:0] word_idx_t;

  // Status register sits directly after the data registers
  function automatic word_idx_t status_idx(input int n_ports);
    return word_idx_t'(n_ports);
  endfunction

  // Mask register sits directly after the status register
  function automatic word_idx_t mask_idx(input int n_ports);
    return word_idx_t'(n_ports + 1);
  endfunction

  function automatic bit cfg_ok(input int n_ports, input int data_w, input int deb_cycles);
    return (n_ports >= MIN_PORTS) && (n_ports <= MAX_PORTS) &&
           (data_w >= MIN_DATA_W) && (data_w <= MAX_DATA_W) &&
           (deb_cycles >= 0) && (deb_cycles <= MAX_DEB_CYCLES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_input_chan.sv
`default_nettype none
// ============================================================================
// Module      : io_input_chan
// Description : One input channel: 2-flop synchroniser, optional debounce
//               filter and the captured data register. o_change flags the
//               edge on which the data register takes a new value.
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_chan
  import io_input_bank_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEB_CYCLES = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_in,
  output logic [DATA_W-1:0] o_data,
  output logic              o_change
);

  logic [DATA_W-1:0] r_sync0;
  logic [DATA_W-1:0] r_sync1;
  logic [DATA_W-1:0] r_data;
  logic              w_load;
  logic              w_change;

  // Two-flop synchroniser for the asynchronous input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
    end else begin
      r_sync0 <= i_in;
      r_sync1 <= r_sync0;
    end
  end

  generate
    if (DEB_CYCLES == 0) begin : g_no_deb
      assign w_load = 1'b1;
    end else begin : g_deb
      localparam logic [CNT_W-1:0] c_DEB_MAX = CNT_W'(DEB_CYCLES);

      logic [DATA_W-1:0] r_prev;
      logic [CNT_W-1:0]  r_cnt;

      // Stability counter: restarts on any change, saturates at the threshold
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_prev <= '0;
          r_cnt  <= '0;
        end else begin
          r_prev <= r_sync1;
          if (r_sync1 != r_prev) begin
            r_cnt <= '0;
          end else if (r_cnt != c_DEB_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_load = (r_cnt == c_DEB_MAX) && (r_sync1 == r_prev);
    end
  endgenerate

  // Only a load that alters the value counts as a change
  assign w_change = w_load && (r_sync1 != r_data);

  // Captured data register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (w_change) begin
      r_data <= r_sync1;
    end
  end

  assign o_data   = r_data;
  assign o_change = w_change;

endmodule
`default_nettype wire

// File: rtl/io_input_bank.sv
`default_nettype none
// ============================================================================
// Module      : io_input_bank
// Description : Bank of N_PORTS synchronised/debounced input ports with a
//               memory-mapped data/status/mask register file and a level
//               interrupt raised when a masked status bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_bank
  import io_input_bank_pkg::*;
#(
  parameter int N_PORTS    = 3,
  parameter int DATA_W     = 32,
  parameter int DEB_CYCLES = 0
) (
  input  logic                      io_clk,
  input  logic                      resetn,
  input  logic [31:0]               addr,
  input  logic                      wr_en,
  input  logic [31:0]               wdata,
  input  logic [N_PORTS*DATA_W-1:0] in_port,
  output logic [31:0]               io_read_data,
  output logic                      irq
);

  localparam word_idx_t c_STATUS_IDX = status_idx(N_PORTS);
  localparam word_idx_t c_MASK_IDX   = mask_idx(N_PORTS);

  generate
    if (!cfg_ok(N_PORTS, DATA_W, DEB_CYCLES)) begin : g_bad_cfg
      $error("io_input_bank: parameter out of legal range");
    end
  endgenerate

  word_idx_t          w_idx;
  logic [DATA_W-1:0]  w_data [N_PORTS];
  logic [N_PORTS-1:0] w_change;
  logic [N_PORTS-1:0] w_clr;
  logic               w_wr_status;
  logic               w_wr_mask;
  logic [REG_W-1:0]   w_rdata;
  logic               w_unused;

  logic [N_PORTS-1:0] r_status;
  logic [N_PORTS-1:0] r_mask;
  logic               r_irq;

  assign w_idx    = addr[7:2];
  assign w_unused = ^{addr[31:8], addr[1:0], wdata[31:N_PORTS]};

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_chan
      io_input_chan #(
        .DATA_W     (DATA_W),
        .DEB_CYCLES (DEB_CYCLES)
      ) u_chan (
        .i_clk    (io_clk),
        .i_rst_n  (resetn),
        .i_in     (in_port[gi*DATA_W +: DATA_W]),
        .o_data   (w_data[gi]),
        .o_change (w_change[gi])
      );
    end
  endgenerate

  assign w_wr_status = wr_en && (w_idx == c_STATUS_IDX);
  assign w_wr_mask   = wr_en && (w_idx == c_MASK_IDX);
  assign w_clr       = w_wr_status ? wdata[N_PORTS-1:0] : '0;

  // Status (W1C, set wins over clear), mask and registered interrupt
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_status <= '0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_change;
      if (w_wr_mask) begin
        r_mask <= wdata[N_PORTS-1:0];
      end
      r_irq <= |(r_status & r_mask);
    end
  end

  // Zero-wait-state read mux; unmapped indices and unused bits read 0
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_idx == word_idx_t'(i)) begin
        w_rdata[DATA_W-1:0] = w_data[i];
      end
    end
    if (w_idx == c_STATUS_IDX) begin
      w_rdata[N_PORTS-1:0] = r_status;
    end else if (w_idx == c_MASK_IDX) begin
      w_rdata[N_PORTS-1:0] = r_mask;
    end
  end

  assign io_read_data = w_rdata;
  assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_input_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_input_bank
// Description : Directed bench for io_input_bank; one instance without
//               debounce and one with DEB_CYCLES=4 share the CPU bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_input_bank;

  localparam int NP = 3;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic [31:0]       addr;
  logic              wr_en;
  logic [31:0]       wdata;
  logic [NP*DW-1:0]  in0;
  logic [NP*DW-1:0]  in4;
  logic [31:0]       rdata0;
  logic [31:0]       rdata4;
  logic              irq0;
  logic              irq4;

  int checks = 0;
  int errors = 0;
  logic [31:0] q_exp[$];

  always #5 clk = ~clk;

  io_input_bank #(.N_PORTS(NP), .DATA_W(DW), .DEB_CYCLES(0)) u_dut0 (
    .io_clk       (clk),
    .resetn       (resetn),
    .addr         (addr),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .in_port      (in0),
    .io_read_data (rdata0),
    .irq          (irq0)
  );

  io_input_bank #(.N_PORTS(NP), .DATA_W(DW), .DEB_CYCLES(4)) u_dut4 (
    .io_clk       (clk),
    .resetn       (resetn),
    .addr         (addr),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .in_port      (in4),
    .io_read_data (rdata4),
    .irq          (irq4)
  );

  // Advance one rising edge; return 1 time unit after it
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (q_exp.size() == 0) begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=<none queued>", tag, obs);
    end else begin
      e = q_exp.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, e);
      end
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v0, output logic [31:0] v4);
    addr = a;
    #1;
    v0 = rdata0;
    v4 = rdata4;
  endtask

  // Read a byte address from one instance and compare
  task automatic ckr(input string tag, input bit dut4, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] v0;
    logic [31:0] v4;
    q_exp.push_back(e);
    rd(a, v0, v4);
    chk(tag, dut4 ? v4 : v0);
  endtask

  task automatic ckirq(input string tag, input bit dut4, input logic e);
    q_exp.push_back({31'b0, e});
    chk(tag, {31'b0, (dut4 ? irq4 : irq0)});
  endtask

  // One-cycle CPU write to a word index
  task automatic wr(input int idx, input logic [31:0] d);
    addr  = 32'(idx) << 2;
    wdata = d;
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    addr   = '0;
    wr_en  = 1'b0;
    wdata  = '0;
    in0    = '0;
    in4    = '0;
    tick(3);
    ckr("rst_data0", 0, 32'h0, 32'h0);
    ckr("rst_status4", 1, 32'hC, 32'h0);
    ckirq("rst_irq4", 1, 1'b0);
    resetn = 1'b1;
    tick(1);

    // Undebounced latency: value visible after exactly 3 edges
    in0[31:0] = 32'h1234_5678;
    tick(2);
    ckr("d0_edge2", 0, 32'h0, 32'h0);
    tick(1);
    ckr("d0_edge3", 0, 32'h0, 32'h1234_5678);
    ckr("d0_status", 0, 32'hC, 32'h1);
    ckirq("d0_irq_masked", 0, 1'b0);

    // Short glitch on port 1 must be filtered
    in4[63:32] = 32'hA5;
    tick(3);
    in4[63:32] = 32'h0;
    tick(12);
    ckr("glitch_data1", 1, 32'h4, 32'h0);
    ckr("glitch_status", 1, 32'hC, 32'h0);

    wr(4, 32'h2);
    ckirq("mask_irq0", 0, 1'b0);

    // Stable change: data on edge 8, irq on edge 9
    in4[63:32] = 32'hA5;
    tick(7);
    ckr("deb_edge7", 1, 32'h4, 32'h0);
    ckirq("deb_irq_e7", 1, 1'b0);
    tick(1);
    ckr("deb_edge8", 1, 32'h4, 32'hA5);
    ckr("deb_status_e8", 1, 32'hC, 32'h2);
    ckirq("deb_irq_e8", 1, 1'b0);
    tick(1);
    ckirq("deb_irq_e9", 1, 1'b1);

    // W1C, then a clear colliding with a new set
    wr(3, 32'h2);
    ckr("w1c_status", 1, 32'hC, 32'h0);
    ckirq("w1c_irq_same", 1, 1'b1);
    tick(1);
    ckirq("w1c_irq_next", 1, 1'b0);
    in4[63:32] = 32'h5A;
    tick(7);
    wr(3, 32'h2);
    ckr("coll_status", 1, 32'hC, 32'h2);
    ckr("coll_data1", 1, 32'h4, 32'h5A);
    tick(1);
    ckirq("coll_irq", 1, 1'b1);
    wr(3, 32'h2);
    ckr("clr2_status", 1, 32'hC, 32'h0);
    ckirq("clr2_irq_same", 1, 1'b1);
    tick(1);
    ckirq("clr2_irq_next", 1, 1'b0);

    // Unmapped reads, address aliasing and ignored writes
    ckr("rd_idx5", 1, 32'h14, 32'h0);
    ckr("rd_idx63", 1, 32'hFC, 32'h0);
    ckr("rd_mask", 1, 32'h10, 32'h2);
    ckr("rd_alias", 0, 32'h400, 32'h1234_5678);
    wr(0, 32'hFFFF_FFFF);
    wr(1, 32'hFFFF_FFFF);
    wr(5, 32'hFFFF_FFFF);
    ckr("wr_data0", 0, 32'h0, 32'h1234_5678);
    ckr("wr_data1", 1, 32'h4, 32'h5A);
    ckr("wr_mask", 1, 32'h10, 32'h2);
    tick(1);
    ckr("wr_status0", 0, 32'hC, 32'h1);

    // Asynchronous reset in the middle of a debounce count
    in4[63:32] = 32'h33;
    tick(5);
    resetn = 1'b0;
    ckr("arst_data1", 1, 32'h4, 32'h0);
    ckr("arst_data0", 0, 32'h0, 32'h0);
    ckr("arst_status0", 0, 32'hC, 32'h0);
    ckr("arst_mask", 1, 32'h10, 32'h0);
    resetn = 1'b1;
    tick(3);
    ckr("post_data0", 0, 32'h0, 32'h1234_5678);
    ckr("post_status0", 0, 32'hC, 32'h1);
    tick(4);
    ckr("post_edge7", 1, 32'h4, 32'h0);
    tick(1);
    ckr("post_edge8", 1, 32'h4, 32'h33);
    ckr("post_status4", 1, 32'hC, 32'h2);
    ckirq("post_irq4", 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_input_bank.md
IO_INPUT_BANK -- requirements
Module: io_input_bank

Interface
REQ-001 Parameter N_PORTS, default 3, number of input ports, legal range 1..8.
REQ-002 Parameter DATA_W, default 32, width of each port, legal range 1..32.
REQ-003 Parameter DEB_CYCLES, default 0, debounce stability count, legal range 0..255; 0 disables debounce.
REQ-004 io_clk  input  1  single block clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 addr  input  32  CPU word address; only addr[7:2] is decoded as the word index.
REQ-007 wr_en  input  1  CPU write strobe, sampled on the io_clk rising edge.
REQ-008 wdata  input  32  CPU write data.
REQ-009 in_port  input  N_PORTS*DATA_W  external asynchronous inputs; port i occupies bits [i*DATA_W +: DATA_W].
REQ-010 io_read_data  output  32  combinational read data for the current addr.
REQ-011 irq  output  1  registered, level-high interrupt request.

Function
REQ-012 Each port SHALL pass through a 2-flop synchroniser (sync0, sync1) before any other use.
REQ-013 DEB_CYCLES=0: data_reg[i] SHALL load sync1[i] every edge, giving a latency of exactly 3 rising edges from the first sampling edge.
REQ-014 DEB_CYCLES=D>0: per port, a prev register SHALL hold the previous sync1 value, and a cnt counter SHALL clear when sync1!=prev, increment when sync1==prev, and saturate at D.
REQ-015 DEB_CYCLES=D>0: data_reg[i] SHALL load sync1 on an edge where cnt==D, sync1==prev and sync1!=data_reg; total latency is exactly D+4 edges.
REQ-016 A glitch shorter than D+1 stable cycles SHALL NOT change data_reg.
REQ-017 status[i] SHALL set on the same edge on which data_reg[i] changes value.
REQ-018 The register map SHALL be: index 0..N_PORTS-1 = data_reg[i] zero-extended to 32 bits; index N_PORTS = status in bits [N_PORTS-1:0]; index N_PORTS+1 = mask in bits [N_PORTS-1:0]; any other index reads 0.
REQ-019 Reads SHALL have zero wait states, with no side effects.
REQ-020 A write to the status index SHALL clear each status bit where wdata is 1 (write-1-to-clear).
REQ-021 A write to the mask index SHALL load mask from wdata[N_PORTS-1:0].
REQ-022 Writes to any other index SHALL be ignored.
REQ-023 If a status set and a W1C clear of the same bit fall on the same edge, the set SHALL win.
REQ-024 irq SHALL be loaded each edge with |(status & mask) as it stands before that edge, i.e. one edge after status or mask changes.
REQ-025 All unused upper bits of io_read_data SHALL be 0.

Reset
REQ-026 When resetn is low, sync0, sync1, prev, data_reg, cnt, status, mask and irq SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count; after release, a change SHALL take the full latency again.
REQ-028 After reset release, a port whose input is already nonzero SHALL set its status bit once data_reg updates.

Structure
REQ-029 Register-index offsets (STATUS_IDX = N_PORTS, MASK_IDX = N_PORTS+1) and parameter range limits SHALL live in the shared io package.
REQ-030 Per-port synchroniser, debounce and data_reg logic SHALL be one sub-module, io_input_chan, instantiated N_PORTS times through a generate loop.
REQ-031 Address decode, status, mask, irq and the read mux SHALL stay in io_input_bank.

Verification
REQ-032 Reset, then in_port0=0x12345678 with D=0: read of index 0 returns 0 after 2 edges and 0x12345678 after the 3rd edge; status=0x1.
REQ-033 D=4: port1 toggles to 0xA5 for 3 cycles then back to 0: data_reg1 stays 0, status stays 0.
REQ-034 D=4: port1 holds 0xA5: data appears on exactly edge 8; mask=0x2 gives irq=1 on edge 9.
REQ-035 Write 0x2 to the status index on the same edge as a new port1 change: status bit1 remains 1; a later W1C clears it and irq drops 1 edge later.
REQ-036 Reads of index N_PORTS+2 and of 63 return 0; writes to data indices leave data_reg unchanged.
REQ-037 Assert resetn low mid-debounce (cnt=2) without a clock edge: all outputs read 0 immediately; after release, full D+4 latency applies.
